// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves conditional branches and serves 2-bit BHT predictions to fetch
// Ports: clk/reset (async, active-high); fetch_pc -> predict_taken (combinational BHT read);
//   resolve_* + alu_result/zero_flag -> branch, mispredict, illegal_branch (registered pulses);
//   branch_count/mispredict_count are live only when BRANCH_STATS_EN is defined, else tied to 0.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             predict_taken,
  input  logic             resolve_valid,
  input  logic [XLEN-1:0]  resolve_pc,
  input  logic [31:0]      resolve_instruction,
  input  logic             resolve_predicted,
  input  logic             alu_result,
  input  logic             zero_flag,
  output logic             branch,
  output logic             mispredict,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [1:0] r_bht [BHT_DEPTH];
  logic [IW-1:0] w_fidx, w_ridx;
  logic [2:0] w_f3;
  logic [1:0] w_cur, w_nxt;
  logic w_qual, w_illegal, w_legal, w_taken, w_unused;
  logic r_branch, r_mispredict, r_illegal;
  assign w_fidx = fetch_pc[IW+1:2];
  assign w_ridx = resolve_pc[IW+1:2];
  assign w_unused = ^{fetch_pc[XLEN-1:IW+2], fetch_pc[1:0], resolve_pc[XLEN-1:IW+2], resolve_pc[1:0],
                      resolve_instruction[31:15], resolve_instruction[11:7]};
  assign predict_taken = r_bht[w_fidx][1];
  assign w_f3 = resolve_instruction[14:12];
  assign w_qual = resolve_valid && (resolve_instruction[6:0] == 7'b1100011);
  assign w_illegal = w_qual && (w_f3[2:1] == 2'b01);
  assign w_legal = w_qual && (w_f3[2:1] != 2'b01);
  // funct3[2] picks the less-than flag over the zero flag; funct3[0] inverts the sense
  assign w_taken = (w_f3[2] ? alu_result : zero_flag) ^ w_f3[0];
  assign w_cur = r_bht[w_ridx];
  always_comb w_nxt = w_taken ? ((w_cur == 2'b11) ? w_cur : w_cur + 2'b01)
                              : ((w_cur == 2'b00) ? w_cur : w_cur - 2'b01);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
      r_branch     <= 1'b0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      if (w_legal) r_bht[w_ridx] <= w_nxt;
      r_branch     <= w_legal & w_taken;
      r_mispredict <= w_legal & (w_taken ^ resolve_predicted);
      r_illegal    <= w_illegal;
    end
  assign branch = r_branch;
  assign mispredict = r_mispredict;
  assign illegal_branch = r_illegal;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_count, r_mispredict_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_legal) begin
      r_branch_count <= r_branch_count + 1'b1;
      if (w_taken ^ resolve_predicted) r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  assign branch_count = r_branch_count;
  assign mispredict_count = r_mispredict_count;
`else
  assign branch_count = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the RISC-V core. Resolves conditional branches from the ALU flags using the same funct3 rules as the current combinational decision logic. Adds registered outputs, a branch history table (BHT) of 2-bit saturating counters that serves predictions to fetch, misprediction detection, and optional performance counters. Sits between the execute stage (resolution inputs) and the fetch stage (prediction output).

## Interface
- `XLEN`, 32, PC width.
- `BHT_DEPTH`, 64, number of BHT entries; power of two, ≥ 2.
- `CNT_W`, 32, width of each statistics counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_pc`  in  XLEN  PC of the instruction being fetched.
- `predict_taken`  out  1  combinational prediction for `fetch_pc`.
- `resolve_valid`  in  1  execute stage presents a resolvable instruction this cycle.
- `resolve_pc`  in  XLEN  PC of the resolving instruction.
- `resolve_instruction`  in  32  full instruction word being resolved.
- `resolve_predicted`  in  1  prediction carried down the pipeline for this instruction.
- `alu_result`  in  1  ALU less-than result (signed or unsigned per funct3).
- `zero_flag`  in  1  ALU equality/zero flag.
- `branch`  out  1  registered: resolved branch is taken.
- `mispredict`  out  1  registered: actual outcome ≠ `resolve_predicted`.
- `illegal_branch`  out  1  registered: branch opcode with funct3 010 or 011.
- `branch_count`  out  CNT_W  resolved legal branches (see Configuration).
- `mispredict_count`  out  CNT_W  mispredictions (see Configuration).

## Operation
- Index: `idx = pc[$clog2(BHT_DEPTH)+1:2]`. The same indexing applies to `fetch_pc` and `resolve_pc`.
- `predict_taken = BHT[idx(fetch_pc)][1]`.
- An instruction qualifies for resolution when `resolve_valid=1` and `resolve_instruction[6:0]=7'b1100011`. For non-qualifying cycles there is no BHT update and all three flags pulse 0.
- Outcome decode on funct3 = `resolve_instruction[14:12]`:
  - 000 BEQ: `zero_flag`
  - 001 BNE: `~zero_flag`
  - 100 BLT / 110 BLTU: `alu_result`
  - 101 BGE / 111 BGEU: `~alu_result`
  - 010 / 011: illegal. `taken=0`, `illegal_branch=1`, `mispredict=0`, no BHT or counter update.
- Per-entry counter states: SNT=00, WNT=01, WT=10, ST=11.
  - Taken: SNT→WNT→WT→ST, with ST held.
  - Not taken: ST→WT→WNT→SNT, with SNT held.
- `mispredict = taken ^ resolve_predicted`. Valid for legal branches only.

## Timing
- Resolution latency is 1 cycle. `branch`, `mispredict` and `illegal_branch` reflect the resolve inputs sampled at edge N during cycle N+1. They are single-cycle pulses and read 0 when the previous cycle did not qualify.
- Back-to-back resolves every cycle are supported with no bubbles.
- The BHT write for a resolve takes effect at the sampling edge. A prediction is visible on `predict_taken` the cycle after that edge.
- Same-index fetch and resolve in one cycle: `predict_taken` shows the pre-update value (read-before-write).
- Reset values:
  - All BHT entries = WNT (01), so `predict_taken=0` for every PC.
  - `branch`, `mispredict`, `illegal_branch` = 0.
  - Both counters = 0.
- Reset asserted mid-operation forces all of the above immediately (asynchronously). Any resolve sampled during reset is discarded.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `branch_count` increments on every legal qualifying resolve.
  - `mispredict_count` increments when that resolve also mispredicts.
  - Both are registered, update on the same edge as the flags, and wrap modulo 2^CNT_W.
- `BRANCH_STATS_EN` undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Reset, then sweep `fetch_pc` over 0x0…0xFC → `predict_taken=0` for all; all flags and counters are 0.
- BEQ (0x00208463) at pc 0x40, `zero_flag=1`, `resolve_predicted=0` → next cycle `branch=1`, `mispredict=1`. Then `fetch_pc=0x40` → `predict_taken=1` (WT). With stats, `branch_count=1`, `mispredict_count=1`.
- BGEU at pc 0x80 with `alu_result=0`, resolved 4 cycles back-to-back → counter saturates at ST. Four not-taken resolves then give `predict_taken` sequence 1,1,0,0.
- funct3=010 with opcode 1100011 → `illegal_branch=1`, `branch=0`, `mispredict=0`; BHT entry and counters unchanged. Non-branch opcode 0x00000013 with `resolve_valid=1` → all flags 0.
- Same-cycle `fetch_pc=resolve_pc=0x10` with a taken resolve from WNT → `predict_taken=0` that cycle and 1 the next.
- Assert `reset` mid-burst while `branch=1` → `branch`=0 immediately, BHT returns to WNT, counters return to 0.
